// File: rtl/s1_result_collector.sv
// Block collector downstream of s1: accumulates sum(x), max(z) and count(x<0)
// over blocks of BLOCK_LEN samples and offers each summary on a valid/ready port.
module s1_result_collector #(
    parameter int BLOCK_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  z_in,
    input  logic signed [15:0] x_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [23:0] sum_out,
    output logic signed [7:0]  zmax_out,
    output logic [7:0]         neg_cnt,
    output logic [7:0]         len_out
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0] BLOCK_LEN_C = 8'(BLOCK_LEN);

    state_t             state_q, state_d;
    logic signed [23:0] acc_q, acc_d;
    logic signed [7:0]  zmax_q, zmax_d;
    logic [7:0]         neg_q, neg_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               accept_s;
    logic               close_s;
    logic [7:0]         cnt_inc_s;

    // Next-state and accumulator update logic
    always_comb begin
        accept_s    = in_valid && (state_q == ACCUM);
        cnt_inc_s   = cnt_q + 8'd1;
        close_s     = 1'b0;
        state_d     = state_q;
        acc_d       = acc_q;
        zmax_d      = zmax_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        case (state_q)
            ACCUM: begin
                if (accept_s) begin
                    acc_d = acc_q + {{8{x_in[15]}}, x_in};
                    neg_d = neg_q + {7'd0, x_in[15]};
                    cnt_d = cnt_inc_s;
                    // The first sample seeds the max so all-negative blocks report correctly
                    if ((cnt_q == 8'd0) || (z_in > zmax_q)) begin
                        zmax_d = z_in;
                    end else begin
                        zmax_d = zmax_q;
                    end
                end else begin
                    acc_d  = acc_q;
                    zmax_d = zmax_q;
                    neg_d  = neg_q;
                    cnt_d  = cnt_q;
                end
                close_s = (accept_s && (cnt_inc_s == BLOCK_LEN_C)) ||
                          (flush && ((cnt_q != 8'd0) || accept_s));
                if (close_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = 24'sd0;
                    zmax_d  = 8'sd0;
                    neg_d   = 8'd0;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ACCUM;
                acc_d   = 24'sd0;
                zmax_d  = 8'sd0;
                neg_d   = 8'd0;
                cnt_d   = 8'd0;
            end
        endcase
        in_ready_d  = (state_d == ACCUM);
        out_valid_d = (state_d == HOLD);
    end

    // State, accumulators and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ACCUM;
            acc_q       <= 24'sd0;
            zmax_q      <= 8'sd0;
            neg_q       <= 8'd0;
            cnt_q       <= 8'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            zmax_q      <= zmax_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_out   = acc_q;
    assign zmax_out  = zmax_q;
    assign neg_cnt   = neg_q;
    assign len_out   = cnt_q;

endmodule

// File: tb/tb_s1_result_collector.sv
// Self-checking bench for s1_result_collector: directed scenarios plus random
// traffic compared against a queue-based block model.
module tb_s1_result_collector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DUT with default block length
    logic               in_valid, in_ready, flush, out_valid, out_ready;
    logic signed [7:0]  z_in, zmax_out;
    logic signed [15:0] x_in;
    logic signed [23:0] sum_out;
    logic [7:0]         neg_cnt, len_out;

    // DUT with maximum block length
    logic               in_valid2, in_ready2, flush2, out_valid2, out_ready2;
    logic signed [7:0]  z_in2, zmax_out2;
    logic signed [15:0] x_in2;
    logic signed [23:0] sum_out2;
    logic [7:0]         neg_cnt2, len_out2;

    s1_result_collector #(.BLOCK_LEN(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .z_in(z_in), .x_in(x_in), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .sum_out(sum_out), .zmax_out(zmax_out),
        .neg_cnt(neg_cnt), .len_out(len_out)
    );

    s1_result_collector #(.BLOCK_LEN(255)) dut255 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .z_in(z_in2), .x_in(x_in2), .flush(flush2), .out_valid(out_valid2),
        .out_ready(out_ready2), .sum_out(sum_out2), .zmax_out(zmax_out2),
        .neg_cnt(neg_cnt2), .len_out(len_out2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: the open block as a list of samples plus a hold flag
    int mx[$];
    int mz[$];
    bit m_hold = 1'b0;

    function automatic int m_sum();
        int s = 0;
        foreach (mx[i]) s += mx[i];
        return s;
    endfunction

    function automatic int m_max();
        int m = -1000;
        foreach (mz[i]) if (mz[i] > m) m = mz[i];
        return m;
    endfunction

    function automatic int m_neg();
        int n = 0;
        foreach (mx[i]) if (mx[i] < 0) n++;
        return n;
    endfunction

    // Drive one cycle on the 8-sample DUT and advance the model by the same rules
    task automatic step(input bit v, input int x, input int z, input bit fl, input bit ord);
        in_valid = v; x_in = 16'(x); z_in = 8'(z); flush = fl; out_ready = ord;
        if (!m_hold) begin
            if (v) begin
                mx.push_back(x);
                mz.push_back(z);
            end
            if ((v && mx.size() == 8) || (fl && mx.size() > 0)) m_hold = 1'b1;
        end else if (ord) begin
            mx.delete();
            mz.delete();
            m_hold = 1'b0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    endtask

    task automatic step2(input bit v, input int x, input bit ord);
        in_valid2 = v; x_in2 = 16'(x); z_in2 = 8'sd3; out_ready2 = ord;
        @(posedge clk); #1;
        in_valid2 = 1'b0; out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        logic [49:0] got;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom); x_in = 16'($urandom); z_in = 8'($urandom);
            flush = 1'($urandom); out_ready = 1'($urandom);
            in_valid2 = 1'($urandom); x_in2 = 16'($urandom); flush2 = 1'($urandom);
            @(posedge clk); #1;
        end
        got = {out_valid, in_ready, sum_out, zmax_out, neg_cnt, len_out};
        checks++;
        if (got !== {1'b0, 1'b1, 48'h0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got, {1'b0, 1'b1, 48'h0});
        end
        checks++;
        if ({out_valid2, in_ready2, sum_out2, len_out2} !== {1'b0, 1'b1, 32'h0}) begin
            failures++;
            $display("FAIL reset_state_255 out_valid=%b in_ready=%b sum=%0d", out_valid2, in_ready2, sum_out2);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; flush2 = 1'b0; out_ready2 = 1'b0;
        rst = 1'b1;
        step(1'b1, 1000, 20, 1'b0, 1'b0);
        step(1'b1, -3000, 40, 1'b0, 1'b0);
        step(1'b1, 7, -2, 1'b0, 1'b0);
        checks++;
        if (sum_out !== 24'(-1993) || len_out !== 8'd3) begin
            failures++;
            $display("FAIL pre_reset_accum sum=%0d len=%0d exp sum=-1993 len=3", sum_out, len_out);
        end
        // Reassert mid-block between clock edges
        rst = 1'b0; #1;
        got = {out_valid, in_ready, sum_out, zmax_out, neg_cnt, len_out};
        checks++;
        if (got !== {1'b0, 1'b1, 48'h0}) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", got, {1'b0, 1'b1, 48'h0});
        end
        mx.delete(); mz.delete(); m_hold = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_full_block();
        int xs[8] = '{100, -200, 300, -400, 500, -600, 700, -800};
        int zs[8] = '{5, -3, 12, 7, -128, 127, 0, 1};
        logic [49:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL full_ready_before_%0d in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
            end
            step(1'b1, xs[i], zs[i], 1'b0, 1'b1);
        end
        got = {out_valid, in_ready, sum_out, zmax_out, neg_cnt, len_out};
        exp = {1'b1, 1'b0, 24'(-400), 8'(127), 8'd4, 8'd8};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL full_block got=%h exp=%h", got, exp);
        end
        checks++;
        if (sum_out !== 24'(m_sum()) || zmax_out !== 8'(m_max()) || neg_cnt !== 8'(m_neg())) begin
            failures++;
            $display("FAIL full_block_model sum=%0d exp=%0d", sum_out, m_sum());
        end
        step(1'b1, 11, 1, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || len_out !== 8'd0) begin
            failures++;
            $display("FAIL full_after_handshake in_ready=%b out_valid=%b len=%0d exp 1/0/0", in_ready, out_valid, len_out);
        end
    endtask

    task automatic test_backpressure();
        int xs[8] = '{100, -200, 300, -400, 500, -600, 700, -800};
        int zs[8] = '{5, -3, 12, 7, -128, 127, 0, 1};
        logic [49:0] got, exp;
        for (int i = 0; i < 8; i++) step(1'b1, xs[i], zs[i], 1'b0, 1'b0);
        exp = {1'b1, 1'b0, 24'(-400), 8'(127), 8'd4, 8'd8};
        for (int i = 0; i < 5; i++) begin
            got = {out_valid, in_ready, sum_out, zmax_out, neg_cnt, len_out};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL backpressure_hold_%0d got=%h exp=%h", i, got, exp);
            end
            step(1'b1, 9, 2, 1'b0, 1'b0);
        end
        step(1'b1, 9, 2, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || len_out !== 8'd0) begin
            failures++;
            $display("FAIL backpressure_no_accept in_ready=%b out_valid=%b len=%0d exp 1/0/0", in_ready, out_valid, len_out);
        end
        step(1'b1, 9, 2, 1'b1, 1'b0);
        checks++;
        if ({out_valid, sum_out, len_out} !== {1'b1, 24'sd9, 8'd1}) begin
            failures++;
            $display("FAIL backpressure_next_first valid=%b sum=%0d len=%0d exp 1/9/1", out_valid, sum_out, len_out);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_flush();
        step(1'b1, 1, -5, 1'b0, 1'b0);
        step(1'b1, 2, -9, 1'b0, 1'b0);
        step(1'b1, 3, -7, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        checks++;
        if ({out_valid, len_out, sum_out, zmax_out} !== {1'b1, 8'd3, 24'sd6, 8'(-5)}) begin
            failures++;
            $display("FAIL flush_partial valid=%b len=%0d sum=%0d zmax=%0d exp 1/3/6/-5", out_valid, len_out, sum_out, zmax_out);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b1, 1, 4, 1'b0, 1'b0);
        step(1'b1, 2, 4, 1'b0, 1'b0);
        step(1'b1, 3, 4, 1'b0, 1'b0);
        step(1'b1, -40, 50, 1'b1, 1'b0);
        checks++;
        if ({out_valid, len_out, sum_out, zmax_out, neg_cnt} !== {1'b1, 8'd4, 24'(-34), 8'sd50, 8'd1}) begin
            failures++;
            $display("FAIL flush_with_sample len=%0d sum=%0d zmax=%0d neg=%0d exp 4/-34/50/1", len_out, sum_out, zmax_out, neg_cnt);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || len_out !== 8'd0) begin
            failures++;
            $display("FAIL flush_empty out_valid=%b in_ready=%b len=%0d exp 0/1/0", out_valid, in_ready, len_out);
        end
        step(1'b1, 10, 1, 1'b0, 1'b0);
        step(1'b1, 20, 1, 1'b1, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || len_out !== 8'd2 || sum_out !== 24'sd30) begin
            failures++;
            $display("FAIL flush_in_hold valid=%b len=%0d sum=%0d exp 1/2/30", out_valid, len_out, sum_out);
        end
        step(1'b0, 0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || len_out !== 8'd0) begin
            failures++;
            $display("FAIL flush_not_remembered out_valid=%b in_ready=%b len=%0d exp 0/1/0", out_valid, in_ready, len_out);
        end
    endtask

    task automatic test_first_max();
        step(1'b1, 5, -100, 1'b0, 1'b0);
        step(1'b1, 5, -50, 1'b0, 1'b0);
        step(1'b1, 5, -120, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || zmax_out !== 8'(-50)) begin
            failures++;
            $display("FAIL first_sample_max valid=%b zmax=%0d exp 1/-50", out_valid, zmax_out);
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int x, z;
        for (int i = 0; i < 400; i++) begin
            x = int'($urandom_range(0, 65535)) - 32768;
            z = int'($urandom_range(0, 255)) - 128;
            step(($urandom % 4) != 0, x, z, ($urandom % 8) == 0, ($urandom % 3) != 0);
            checks++;
            if (in_ready !== !m_hold || out_valid !== m_hold) begin
                failures++;
                $display("FAIL random_hs_%0d in_ready=%b out_valid=%b exp hold=%b", i, in_ready, out_valid, m_hold);
            end
            if (m_hold) begin
                checks++;
                if (sum_out !== 24'(m_sum()) || zmax_out !== 8'(m_max()) ||
                    neg_cnt !== 8'(m_neg()) || len_out !== 8'(mx.size())) begin
                    failures++;
                    $display("FAIL random_summary_%0d sum=%0d/%0d zmax=%0d/%0d neg=%0d/%0d len=%0d/%0d",
                             i, sum_out, m_sum(), zmax_out, m_max(), neg_cnt, m_neg(), len_out, mx.size());
                end
            end
        end
        step(1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    task automatic test_extremes();
        int vals[2] = '{-32768, 32767};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 255; i++) begin
                checks++;
                if (in_ready2 !== 1'b1) begin
                    failures++;
                    $display("FAIL extreme_ready_%0d_%0d in_ready=%b exp 1", k, i, in_ready2);
                end
                step2(1'b1, vals[k], 1'b0);
            end
            checks++;
            if (out_valid2 !== 1'b1 || sum_out2 !== 24'(255 * vals[k]) || len_out2 !== 8'd255 ||
                neg_cnt2 !== ((vals[k] < 0) ? 8'd255 : 8'd0)) begin
                failures++;
                $display("FAIL extreme_block_%0d valid=%b sum=%0d exp=%0d neg=%0d len=%0d",
                         k, out_valid2, sum_out2, 255 * vals[k], neg_cnt2, len_out2);
            end
            step2(1'b0, 0, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; x_in = 16'sd0; z_in = 8'sd0; flush = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; x_in2 = 16'sd0; z_in2 = 8'sd0; flush2 = 1'b0; out_ready2 = 1'b0;
        test_reset();
        test_full_block();
        test_backpressure();
        test_flush();
        test_first_max();
        test_random();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
